// File: rtl/conv_pkg.sv
// Shared definitions for the byte-to-word assembler: FSM state type,
// default geometry and the beat slice placement helper.
package conv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int BYTE_W_DEF  = 8;
  localparam int N_BYTES_DEF = 4;

  // LSB position of beat k inside the assembled word; beat 0 lands in the MSBs.
  function automatic int slice_lsb(input int n_bytes, input int byte_w, input int k);
    return (n_bytes - 1 - k) * byte_w;
  endfunction

endpackage

// File: rtl/conv_8_32_asm.sv
// Assembly datapath: beat counter plus the word being built.
// word is the assembly register with the current input beat already merged
// at the slot selected by count, so the top can capture a complete word on
// the same edge that samples the last beat.
import conv_pkg::*;

module conv_8_32_asm #(
  parameter  int BYTE_W  = BYTE_W_DEF,
  parameter  int N_BYTES = N_BYTES_DEF,
  localparam int CNT_W   = $clog2(N_BYTES),
  localparam int W       = BYTE_W * N_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [BYTE_W-1:0] data,
  output logic [CNT_W-1:0]  count,
  output logic [W-1:0]      word
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BYTES - 1);

  logic [W-1:0] asm_q;
  logic [W-1:0] merged;

  // Merge the incoming beat into its slot of the partial word.
  always_comb begin
    merged = asm_q;
    for (int k = 0; k < N_BYTES; k++) begin
      if (count == CNT_W'(k)) begin
        merged[slice_lsb(N_BYTES, BYTE_W, k) +: BYTE_W] = data;
      end
    end
  end

  assign word = merged;

  // Assembly register and beat counter; clear wins over load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q <= '0;
      count <= '0;
    end else if (clear) begin
      asm_q <= '0;
      count <= '0;
    end else if (load) begin
      asm_q <= merged;
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/conv_8_32.sv
// Byte-to-word assembler: rebuilds N_BYTES-beat words, first beat in the MSBs,
// and strobes valid_out for one cycle per completed word. A valid_in drop
// mid-word discards the partial word.
// Optional: define CONV_8_32_PARTIAL_ERR_EN to enable the err_partial strobe
// and the saturating drop_cnt counter; otherwise err_partial is tied low.
//
// Handshake: valid_in qualifies data_in in the cycle it is high; there is no
// ready, so every beat is consumed and every valid_out strobe must be taken.
import conv_pkg::*;

module conv_8_32 #(
  parameter  int BYTE_W  = BYTE_W_DEF,
  parameter  int N_BYTES = N_BYTES_DEF,
  localparam int W       = BYTE_W * N_BYTES,
  localparam int CNT_W   = $clog2(N_BYTES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [BYTE_W-1:0] data_in,
  output logic [W-1:0]      data_out,
  output logic              valid_out,
  output logic              err_partial,
  output state_t            state
);

  if (N_BYTES < 2 || N_BYTES > 16) begin : g_bad_n_bytes
    $error("conv_8_32: N_BYTES must be in 2..16");
  end

`ifdef CONV_8_32_PARTIAL_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BYTES - 1);

  state_t           state_d;
  logic             load;
  logic             clear;
  logic             done;
  logic             drop;
  logic [CNT_W-1:0] count;
  logic [W-1:0]     word;

  conv_8_32_asm #(
    .BYTE_W  (BYTE_W),
    .N_BYTES (N_BYTES)
  ) u_asm (
    .clk   (clk),
    .rst   (reset),
    .load  (load),
    .clear (clear),
    .data  (data_in),
    .count (count),
    .word  (word)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state and datapath controls.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    clear   = 1'b0;
    done    = 1'b0;
    drop    = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid_in) begin
          load    = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (valid_in) begin
          load = 1'b1;
          if (count == LAST) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          clear   = 1'b1;
          drop    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output registers: data_out only changes on a completed word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out    <= '0;
      valid_out   <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      if (done) data_out <= word;
      valid_out   <= done;
      err_partial <= drop & ERR_EN;
    end
  end

`ifdef CONV_8_32_PARTIAL_ERR_EN
  logic [7:0] drop_cnt;

  // Sticky count of dropped partial words, saturating at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_conv_8_32.sv
// Bench for conv_8_32: directed steps from the test plan followed by a random
// stream, all checked cycle by cycle against a queue-based reference model.
// A second instance with N_BYTES=2 covers the short-word configuration.
import conv_pkg::*;

module tb_conv_8_32;

`ifdef CONV_8_32_PARTIAL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (N_BYTES = 4)
  logic        valid_in = 1'b0;
  logic [7:0]  data_in  = '0;
  logic [31:0] data_out;
  logic        valid_out;
  logic        err_partial;
  state_t      st;

  conv_8_32 dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .err_partial (err_partial),
    .state       (st)
  );

  // Short-word DUT (N_BYTES = 2)
  logic        valid2 = 1'b0;
  logic [7:0]  data2  = '0;
  logic [15:0] data_out2;
  logic        valid_out2;
  logic        err2;
  state_t      st2;

  conv_8_32 #(.BYTE_W(8), .N_BYTES(2)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid2),
    .data_in     (data2),
    .data_out    (data_out2),
    .valid_out   (valid_out2),
    .err_partial (err2),
    .state       (st2)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0]  beat_q[$];   // beats of the word currently being collected
  logic [31:0] exp_q[$];    // completed words not yet seen on data_out
  logic [31:0] exp_data = '0;
  logic        exp_valid = 1'b0;
  logic        exp_err = 1'b0;
  int          exp_drops = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    beat_q.delete();
    exp_q.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_drops = 0;
  endtask

  // Reference behaviour for one sampled cycle of the 4-byte instance.
  task automatic model_step(input logic v, input logic [7:0] d);
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (v) begin
      beat_q.push_back(d);
      if (beat_q.size() == 4) begin
        exp_q.push_back({beat_q[0], beat_q[1], beat_q[2], beat_q[3]});
        beat_q.delete();
      end
    end else if (beat_q.size() != 0) begin
      exp_err = ERR_EN;
      if (exp_drops < 255) exp_drops++;
      beat_q.delete();
    end
    if (exp_q.size() != 0) begin
      exp_data  = exp_q.pop_front();
      exp_valid = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, 64'(valid_out), 64'(exp_valid));
    chk({tag, "_data"}, 64'(data_out), 64'(exp_data));
    chk({tag, "_err"}, 64'(err_partial), 64'(exp_err));
`ifdef CONV_8_32_PARTIAL_ERR_EN
    chk({tag, "_drops"}, 64'(dut.drop_cnt), 64'(exp_drops));
`endif
  endtask

  // ---------------- driver ----------------
  // Present one beat (or an idle cycle) for one clock, then check.
  task automatic step(input logic v, input logic [7:0] d, input string tag);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    #1;
    model_step(v, d);
    check_outputs(tag);
  endtask

  task automatic word4(input logic [31:0] w, input string tag);
    for (int i = 3; i >= 0; i--) step(1'b1, w[i*8 +: 8], tag);
  endtask

  task automatic idle_after_reset();
    @(negedge clk);
    valid_in = 1'b0;
    valid2   = 1'b0;
    reset    = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] w;
    logic [31:0] held;
    int pulses;

    // Reset values
    #1;
    chk("rst_data", 64'(data_out), 64'h0);
    chk("rst_valid", 64'(valid_out), 64'h0);
    chk("rst_err", 64'(err_partial), 64'h0);
    chk("rst_state", 64'(st), 64'(IDLE));
    repeat (2) @(posedge clk);
    model_reset();
    idle_after_reset();

    // 1) DE AD BE EF
    word4(32'hDEADBEEF, "deadbeef");
    chk("deadbeef_word", 64'(data_out), 64'hDEADBEEF);
    chk("deadbeef_pulse", 64'(valid_out), 64'h1);
    step(1'b0, 8'h00, "deadbeef_after");
    chk("deadbeef_one_cycle", 64'(valid_out), 64'h0);

    // 2) Continuous 01..08
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), "stream");
      if (valid_out) pulses++;
      if (i == 4) chk("stream_w0", 64'(data_out), 64'h01020304);
      if (i == 8) chk("stream_w1", 64'(data_out), 64'h05060708);
    end
    chk("stream_pulses", 64'(pulses), 64'd2);

    // 3) Partial word dropped, then A1..A4
    step(1'b1, 8'h11, "partial");
    step(1'b1, 8'h22, "partial");
    chk("partial_state_fill", 64'(st), 64'(FILL));
    step(1'b0, 8'h00, "partial_drop");
    chk("partial_err_pulse", 64'(err_partial), 64'(ERR_EN));
    chk("partial_no_strobe", 64'(valid_out), 64'h0);
    step(1'b0, 8'h00, "partial_gap");
    chk("partial_err_once", 64'(err_partial), 64'h0);
    word4(32'hA1A2A3A4, "a1a4");
    chk("a1a4_word", 64'(data_out), 64'hA1A2A3A4);

    // 4) Asynchronous reset mid-word after 3 beats
    step(1'b1, 8'h77, "pre_rst");
    step(1'b1, 8'h88, "pre_rst");
    step(1'b1, 8'h99, "pre_rst");
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_data", 64'(data_out), 64'h0);
    chk("async_rst_valid", 64'(valid_out), 64'h0);
    chk("async_rst_err", 64'(err_partial), 64'h0);
    chk("async_rst_state", 64'(st), 64'(IDLE));
    model_reset();
    idle_after_reset();
    word4(32'hCAFEBABE, "cafebabe");
    chk("cafebabe_word", 64'(data_out), 64'hCAFEBABE);

    // 5) 20 idle cycles hold the word
    for (int i = 0; i < 20; i++) step(1'b0, 8'($urandom_range(0, 255)), "idle_hold");
    chk("idle_hold_word", 64'(data_out), 64'hCAFEBABE);

    // 6) N_BYTES = 2 instance: AB CD
    @(negedge clk);
    valid_in = 1'b0;
    valid2 = 1'b1;
    data2  = 8'hAB;
    @(posedge clk);
    #1;
    chk("n2_first_beat_valid", 64'(valid_out2), 64'h0);
    @(negedge clk);
    data2 = 8'hCD;
    @(posedge clk);
    #1;
    chk("n2_valid", 64'(valid_out2), 64'h1);
    chk("n2_data", 64'(data_out2), 64'hABCD);
    @(negedge clk);
    valid2 = 1'b0;
    @(posedge clk);
    #1;
    chk("n2_single_pulse", 64'(valid_out2), 64'h0);
    chk("n2_hold", 64'(data_out2), 64'hABCD);
    chk("n2_err", 64'(err2), 64'h0);
    model_step(1'b0, 8'h00);   // main DUT saw an idle cycle

    // 7) Random stream, mostly valid with occasional drops
    for (int i = 0; i < 400; i++) begin
      w = $urandom();
      step(($urandom_range(0, 5) != 0), w[7:0], "random");
    end

    // Idle tail: the last word must hold
    held = exp_data;
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, "tail");
    chk("tail_hold", 64'(data_out), 64'(held));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
